// File: rtl/riscv_acc_wb_seq.sv
// riscv_acc_wb_seq: snapshots an accelerator result and writes it word-by-word to memory while halting the core
module riscv_acc_wb_seq #(
    parameter int DATA_W      = 32,
    parameter int NUM_WORDS   = 4,
    parameter int ADDR_STRIDE = 4,
    parameter int GAP_CYCLES  = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [31:0]                 base_addr_i,
    input  logic [NUM_WORDS*DATA_W-1:0] data_i,
    input  logic                        reverse_i,
    output logic                        wr_req_o,
    input  logic                        wr_gnt_i,
    output logic [31:0]                 wr_addr_o,
    output logic [DATA_W-1:0]           wr_data_o,
    output logic                        halt_o,
    output logic                        busy_o,
    output logic                        done_o
);
    localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    state_t                           r_state, w_next;
    logic [IW-1:0]                    r_idx, w_idx_n, w_sel;
    logic [GW-1:0]                    r_gap, w_gap_n;
    logic [NUM_WORDS-1:0][DATA_W-1:0] r_data, w_data_n;
    logic [31:0]                      r_base, w_base_n, w_addr_n;
    logic                             r_rev, w_rev_n;
    logic                             w_fire, w_last, w_gap_end;
    logic                             w_req_n, w_halt_n, w_done_n;
    logic [DATA_W-1:0]                w_wdata_n;

    assign w_fire    = r_state == ISSUE && wr_req_o && wr_gnt_i;
    assign w_last    = r_idx == IW'(NUM_WORDS - 1);
    assign w_gap_end = r_gap == GW'(GAP_CYCLES - 1);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state: a granted last word ends the burst, otherwise optionally idle in GAP
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next = ISSUE;
            ISSUE:   if (w_fire) w_next = w_last ? DONE : (GAP_CYCLES > 0 ? GAP : ISSUE);
            GAP:     if (w_gap_end) w_next = ISSUE;
            default: w_next = IDLE;
        endcase
    end

    // next values of the snapshot, word index and gap counter
    always_comb begin
        w_idx_n  = r_idx;
        w_gap_n  = r_gap;
        w_data_n = r_data;
        w_base_n = r_base;
        w_rev_n  = r_rev;
        if (r_state == IDLE && start_i) begin
            w_idx_n  = '0;
            w_data_n = data_i;
            w_base_n = base_addr_i;
            w_rev_n  = reverse_i;
        end
        if (w_fire && !w_last) begin
            w_idx_n = r_idx + IW'(1);
            w_gap_n = '0;
        end
        if (r_state == GAP) w_gap_n = w_gap_end ? '0 : r_gap + GW'(1);
    end

    // output decode from the upcoming state so every output leaves a flop
    always_comb begin
        w_sel     = w_rev_n ? IW'(NUM_WORDS - 1) - w_idx_n : w_idx_n;
        w_req_n   = w_next == ISSUE;
        w_halt_n  = w_next == ISSUE || w_next == GAP;
        w_done_n  = w_next == DONE;
        w_addr_n  = w_req_n ? w_base_n + 32'(w_idx_n) * 32'(ADDR_STRIDE) : '0;
        w_wdata_n = w_req_n ? w_data_n[w_sel] : '0;
    end

    // datapath and output registers; reset aborts any burst without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_gap     <= '0;
            r_data    <= '0;
            r_base    <= '0;
            r_rev     <= 1'b0;
            wr_req_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            halt_o    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            r_idx     <= w_idx_n;
            r_gap     <= w_gap_n;
            r_data    <= w_data_n;
            r_base    <= w_base_n;
            r_rev     <= w_rev_n;
            wr_req_o  <= w_req_n;
            wr_addr_o <= w_addr_n;
            wr_data_o <= w_wdata_n;
            halt_o    <= w_halt_n;
            busy_o    <= w_halt_n;
            done_o    <= w_done_n;
        end
    end
endmodule
